// File: rtl/ramwriter_pkg.sv
// Shared store-writer constants: FSM state codes and the widest store in bytes.
// Imported by the RAM writer and by the control sequencer that picks nbytes.
package ramwriter_pkg;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_WRITE = 2'd1;
    localparam logic [1:0] WR_DONE  = 2'd2;

    localparam logic [3:0] WR_MAXB  = 4'd8;

    function automatic logic nb_legal(input logic [3:0] n);
        return (n != 4'd0) && (n <= WR_MAXB);
    endfunction

endpackage

// File: rtl/ramwriter.sv
// Little-endian multi-byte store into byte-wide RAM, one byte per clock.
// Holds kp high while bytes are going out so the sequencer waits for the store.
module ramwriter
    import ramwriter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 64,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    nbytes,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic          kp,
    output logic          we,
    output logic [AW-1:0] adq,
    output logic [BW-1:0] dq,
    output logic          done
);

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic [DW-1:0] r_shift;
    logic          r_kp;
    logic          r_we;
    logic [AW-1:0] r_adq;
    logic [BW-1:0] r_dq;
    logic          r_done;

    logic          w_accept;
    logic [2:0]    w_last_idx;

    // New requests are taken only between stores; DONE counts as idle.
    assign w_accept   = start && nb_legal(nbytes) &&
                        ((r_state == WR_IDLE) || (r_state == WR_DONE));
    assign w_last_idx = 3'(nbytes - 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WR_IDLE;
            r_cnt   <= 3'd0;
            r_shift <= '0;
            r_kp    <= 1'b0;
            r_we    <= 1'b0;
            r_adq   <= '0;
            r_dq    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                WR_IDLE, WR_DONE: begin
                    if (w_accept) begin
                        r_state <= WR_WRITE;
                        r_shift <= data;
                        r_cnt   <= w_last_idx;
                        r_kp    <= 1'b1;
                        r_we    <= 1'b1;
                        r_adq   <= addr;
                        r_dq    <= data[BW-1:0];
                    end else begin
                        r_state <= WR_IDLE;
                    end
                end
                WR_WRITE: begin
                    if (r_cnt != 3'd0) begin
                        r_shift <= r_shift >> BW;
                        r_dq    <= r_shift[2*BW-1:BW];
                        r_adq   <= r_adq + AW'(1);
                        r_cnt   <= r_cnt - 3'd1;
                    end else begin
                        // Last byte has been presented; adq/dq keep their values.
                        r_state <= WR_DONE;
                        r_we    <= 1'b0;
                        r_kp    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

    assign kp   = r_kp;
    assign we   = r_we;
    assign adq  = r_adq;
    assign dq   = r_dq;
    assign done = r_done;

endmodule
